// File: rtl/dma_pkg.sv
// Shared definitions for the DMA port arbiter.
// Contents: default bus widths, arbiter state encoding, and a helper that
// computes the low bit of requester i's field inside a packed per-requester bus.
package dma_pkg;

    localparam int unsigned DMA_ADDR_W = 26;
    localparam int unsigned DMA_DATA_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    // Low bit of field idx in a bus of equally sized fields of the given width
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/dma_arbiter_rr_pick.sv
// Round-robin pick: combinational rotate-then-priority-encode.
// Ports:
//   req         - request vector, one bit per requester
//   last_grant  - index of the most recently served requester
//   grant       - first requesting index scanning upward from last_grant+1 (mod NREQ)
//   grant_valid - at least one request is present
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [IW-1:0]   grant,
    output logic            grant_valid
);

    logic [NREQ-1:0] rot;

    // Index reached by stepping off positions past base, wrapping at NREQ
    function automatic logic [IW-1:0] wrap(input logic [IW-1:0] base, input int unsigned off);
        return IW'((32'(base) + off) % NREQ);
    endfunction

    // rot[0] is the requester right after last_grant; the lowest set bit wins
    always_comb begin
        rot   = '0;
        grant = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            rot[i] = req[wrap(last_grant, i + 32'd1)];
        end
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                grant = wrap(last_grant, 32'(i) + 32'd1);
            end
        end
        grant_valid = |req;
    end

endmodule

// File: rtl/dma_arbiter.sv
// Round-robin arbiter sharing one memory DMA port among NREQ masters,
// one transaction outstanding at a time.
// Optional build macro: DMA_ARB_TIMEOUT_EN adds a WAIT watchdog that completes
// a stuck transaction with m_err after TIMEOUT_CYCLES; otherwise m_err stays 0.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   m_req/m_read/m_addr/m_wr_data    - upstream requests (packed per requester)
//   m_ack/m_err/m_rd_data            - upstream completion (registered)
//   s_req/s_read/s_addr/s_wr_data    - downstream request (registered, s_req pulses)
//   s_ack/s_rd_data                  - downstream completion
module dma_arbiter
    import dma_pkg::*;
#(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned ADDR_W         = DMA_ADDR_W,
    parameter int unsigned DATA_W         = DMA_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          m_req,
    input  logic [NREQ-1:0]          m_read,
    input  logic [NREQ*ADDR_W-1:0]   m_addr,
    input  logic [NREQ*DATA_W-1:0]   m_wr_data,
    output logic [NREQ-1:0]          m_ack,
    output logic [DATA_W-1:0]        m_rd_data,
    output logic [NREQ-1:0]          m_err,
    output logic                     s_req,
    output logic                     s_read,
    output logic [ADDR_W-1:0]        s_addr,
    output logic [DATA_W-1:0]        s_wr_data,
    input  logic                     s_ack,
    input  logic [DATA_W-1:0]        s_rd_data
);

    localparam int unsigned IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("dma_arbiter: NREQ must be 2..8 and TIMEOUT_CYCLES at least 2");
    end

    arb_state_t          state_q, state_d;
    logic [IW-1:0]       last_grant_q, last_grant_d;
    logic [IW-1:0]       grant_q, grant_d;
    logic [IW-1:0]       pick_grant;
    logic                pick_valid;
    logic                sel_read;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [NREQ-1:0]     m_ack_d, m_err_d;
    logic [DATA_W-1:0]   m_rd_data_d;
    logic                s_req_d, s_read_d;
    logic [ADDR_W-1:0]   s_addr_d;
    logic [DATA_W-1:0]   s_wr_data_d;

`ifdef DMA_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0]       cnt_q, cnt_d;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req         (m_req),
        .last_grant  (last_grant_q),
        .grant       (pick_grant),
        .grant_valid (pick_valid)
    );

    // Operand mux for the requester the picker selected
    always_comb begin
        sel_read  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_grant == IW'(i)) begin
                sel_read  = m_read[i];
                sel_addr  = m_addr[slice_lo(i, ADDR_W) +: ADDR_W];
                sel_wdata = m_wr_data[slice_lo(i, DATA_W) +: DATA_W];
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        m_ack_d      = '0;
        m_err_d      = '0;
        m_rd_data_d  = m_rd_data;
        s_req_d      = 1'b0;
        s_read_d     = s_read;
        s_addr_d     = s_addr;
        s_wr_data_d  = s_wr_data;
`ifdef DMA_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                // While m_ack is out the requester has not yet dropped m_req,
                // so skip sampling for that one cycle to avoid a duplicate grant.
                if (pick_valid && (m_ack == '0)) begin
                    grant_d     = pick_grant;
                    s_req_d     = 1'b1;
                    s_read_d    = sel_read;
                    s_addr_d    = sel_addr;
                    s_wr_data_d = sel_wdata;
                    state_d     = WAIT;
`ifdef DMA_ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            WAIT: begin
                if (s_ack) begin
                    m_ack_d[grant_q] = 1'b1;
                    m_rd_data_d      = s_rd_data;
                    last_grant_d     = grant_q;
                    state_d          = IDLE;
                end
`ifdef DMA_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    m_ack_d[grant_q] = 1'b1;
                    m_err_d[grant_q] = 1'b1;
                    m_rd_data_d      = '0;
                    last_grant_d     = grant_q;
                    state_d          = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= IW'(NREQ - 1);
            grant_q      <= '0;
            m_ack        <= '0;
            m_err        <= '0;
            m_rd_data    <= '0;
            s_req        <= 1'b0;
            s_read       <= 1'b0;
            s_addr       <= '0;
            s_wr_data    <= '0;
`ifdef DMA_ARB_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            m_ack        <= m_ack_d;
            m_err        <= m_err_d;
            m_rd_data    <= m_rd_data_d;
            s_req        <= s_req_d;
            s_read       <= s_read_d;
            s_addr       <= s_addr_d;
            s_wr_data    <= s_wr_data_d;
`ifdef DMA_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

endmodule

// File: doc/dma_arbiter.md
Name: dma_arbiter

Overview:
- Shares the single memory DMA port among NREQ bus masters: the sdhc controller, the CPU-side block copier and future peripherals.
- Round-robin grant; one transaction outstanding at a time.
- Upstream ports carry the same req/ack/read/addr/data signal set as the sdhc DMA port.
- The downstream port connects to the memory controller.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADDR_W, 26, byte address width.
- DATA_W, 32, data word width.
- TIMEOUT_CYCLES, 1024, watchdog limit in WAIT. Used only with the optional feature.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-high reset.
- m_req  in  NREQ  per-requester request, level. Held until that requester's m_ack.
- m_read  in  NREQ  1 = read, 0 = write.
- m_addr  in  NREQ*ADDR_W  packed addresses; requester i occupies [i*ADDR_W +: ADDR_W].
- m_wr_data  in  NREQ*DATA_W  packed write data.
- m_ack  out  NREQ  one-cycle completion pulse to the granted requester.
- m_rd_data  out  DATA_W  read data, broadcast; valid in the m_ack cycle.
- m_err  out  NREQ  timeout flag, coincident with m_ack.
- s_req  out  1  one-cycle request pulse to memory.
- s_read  out  1  direction of the issued transaction.
- s_addr  out  ADDR_W  address of the issued transaction.
- s_wr_data  out  DATA_W  write data of the issued transaction.
- s_ack  in  1  memory completion pulse. Arrives 1 or more cycles after s_req.
- s_rd_data  in  DATA_W  memory read data, valid with s_ack.

Behaviour:
- All outputs are registered.
- Reset values:
  - m_ack = 0, m_err = 0, m_rd_data = 0.
  - s_req = 0, s_read = 0, s_addr = 0, s_wr_data = 0.
  - state = IDLE, last_grant = NREQ-1, so requester 0 wins first after reset.
- State IDLE:
  - If m_req != 0, choose g = the first set bit scanning from last_grant+1 upward, modulo NREQ.
  - Latch g and that requester's read/addr/wr_data into s_* registers, and register s_req = 1.
  - Go to WAIT.
  - If m_req == 0, stay in IDLE.
- State WAIT:
  - s_req is 0; it was high for exactly the first cycle.
  - On s_ack:
    - m_ack[g] = 1 next cycle.
    - m_rd_data = s_rd_data (captured for reads; write cycles also capture, value don't-care).
    - last_grant = g.
    - Go to IDLE.
- Latency:
  - m_req rises in cycle 0 → s_req in cycle 1.
  - With a memory that acks in cycle 2, m_ack is in cycle 3.
  - Minimum 3 cycles per transaction; IDLE inserts one bubble between grants.
- Requester rule: drop m_req, or present the next request, on the clock edge that samples m_ack. IDLE re-samples one cycle after the m_ack cycle, so no duplicate grant occurs.
- Requester inputs are sampled only in IDLE. Changes to them during WAIT are ignored.
- An s_ack received outside WAIT is spurious: ignored, with no state change.
- Simultaneous requests: exactly one grant per IDLE visit. Every requester with m_req held is served within NREQ grants (no starvation).
- m_ack is one-hot or zero, never multi-bit.
- rst asserted mid-transaction:
  - Immediate return to reset values; the in-flight transaction is abandoned with no m_ack.
  - A later stray s_ack is ignored.

Optional Feature:
- Macro: DMA_ARB_TIMEOUT_EN.
- Enabled:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES-1 without s_ack: pulse m_ack[g] and m_err[g] together, set m_rd_data = 0, go to IDLE, advance last_grant.
  - s_ack on the same cycle as the timeout takes priority: normal completion, m_err = 0.
- Disabled: no counter; m_err is tied to 0; WAIT waits indefinitely.

Decomposition:
- Package dma_pkg holds:
  - DMA_ADDR_W = 26 and DMA_DATA_W = 32.
  - State enum: IDLE, WAIT.
  - Helper for slice extraction from the packed buses.
- Sub-module rr_pick: purely combinational, parameterised on NREQ.
  - Inputs: req vector, last_grant.
  - Outputs: grant index, grant_valid.
  - Implemented as a rotate-then-priority-encode, and unit-tested standalone.

Test Plan:
- Single read: memory word 0x400 = 0xDEADBEEF; m_req[0] pulses with m_read = 1, addr 0x1000.
  - s_req one cycle with s_addr = 0x1000.
  - m_ack[0] in cycle 3 with m_rd_data = 0xDEADBEEF; no other m_ack bits.
- Single write: requester 2 writes 0x12345678 to 0x1004 → memory word 0x401 = 0x12345678; m_ack[2] pulses exactly once.
- Fairness: all four m_req held continuously for 8 transactions.
  - Grant order 0,1,2,3,0,1,2,3.
  - Every s_req is separated by ≥1 idle cycle.
- Slow memory plus stray ack: s_ack is delayed 20 cycles, and one extra s_ack is injected in IDLE.
  - The single m_ack occurs 1 cycle after the real s_ack.
  - The stray s_ack causes no m_ack and no state change.
- Reset mid-op: assert rst in WAIT, then deliver s_ack afterwards.
  - No m_ack; all outputs return to reset values.
  - The next request from requester 1 with requester 0 also pending is granted to 0 first.
- DMA_ARB_TIMEOUT_EN with TIMEOUT_CYCLES = 16 and memory never acking:
  - m_ack[0] and m_err[0] pulse 16 cycles after s_req, with m_rd_data = 0.
  - The next pending requester is then granted.
